icache_fill_ctrl: RTL and testbench
===================================

Name: icache_fill_ctrl

Overview:
- Refill sequencer for the pipelined OTTER instruction cache.
- On a cache miss it takes ownership of the memory's instruction read port (MEM_RDEN1 / MEM_ADDR1 / MEM_DOUT1, word-addressed, synchronous 1-cycle read latency).
- Reads one aligned line word by word and streams each word into the cache data array. It then commits the tag/valid entry and releases the fetch stage.
- Also keeps a saturating miss counter for performance measurement.

Parameters:
- WORDS_PER_LINE, 4, words per cache line; power of two, range 2..16.
- ADDR_W, 14, word-address width (PC[15:2]).
- CNT_W, 16, width of the miss counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- MISS  input  1  cache lookup missed this cycle (level; held by the fetch stage until FILL_DONE).
- MISS_ADDR  input  ADDR_W  word address of the missing instruction.
- FLUSH  input  1  pipeline flush / branch redirect; aborts any fill in progress.
- MEM_RDEN1  output  1  read enable to the memory instruction port.
- MEM_ADDR1  output  ADDR_W  word address to the memory instruction port.
- MEM_DOUT1  input  32  instruction word returned one cycle after MEM_RDEN1.
- LINE_WE  output  1  write strobe for one word of the cache data array.
- LINE_IDX  output  log2(WORDS_PER_LINE)  word index within the line being written.
- LINE_DATA  output  32  word to write; equals MEM_DOUT1.
- TAG_WE  output  1  one-cycle strobe: write tag and set the valid bit for the filled line.
- FILL_TAG  output  ADDR_W  line base address (low log2(WORDS_PER_LINE) bits zero).
- STALL  output  1  fetch must hold the PC.
- FILL_DONE  output  1  one-cycle pulse; the line is now valid.
- MISS_COUNT  output  CNT_W  number of fills started since reset, saturating.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state IDLE.
  - MEM_RDEN1, LINE_WE, TAG_WE, FILL_DONE = 0.
  - MEM_ADDR1, LINE_IDX, FILL_TAG, MISS_COUNT = 0.
  - Applies immediately, including mid-fill. No write strobe may be generated in the cycle reset asserts.
- STALL = (state != IDLE) OR (MISS AND NOT FLUSH). STALL is combinational so the fetch stage holds the PC in the miss cycle.
- States: IDLE, ISSUE, DRAIN, COMMIT.
- IDLE:
  - On MISS=1 and FLUSH=0 at the clock edge: latch base = MISS_ADDR with low bits cleared into FILL_TAG.
  - Increment MISS_COUNT (hold at all-ones).
  - Clear the issue counter and go to ISSUE.
- ISSUE:
  - MEM_RDEN1=1, MEM_ADDR1 = base + issue counter.
  - Counter increments each cycle. Once address base+WORDS_PER_LINE-1 has been issued, go to DRAIN.
- Data path:
  - Each read returns data one cycle later. In that cycle LINE_WE=1, LINE_IDX = index issued the previous cycle, LINE_DATA = MEM_DOUT1.
  - LINE_WE is registered from MEM_RDEN1 issued by this block.
- DRAIN:
  - MEM_RDEN1=0; the last word is written (LINE_WE=1).
  - Next state COMMIT.
- COMMIT: TAG_WE=1 and FILL_DONE=1 for exactly one cycle, then IDLE.
- Latency: miss accepted at edge 0 → reads at cycles 1..N → writes at cycles 2..N+1 → COMMIT at cycle N+2 → IDLE at N+3. With N=4: 7 cycles of STALL including the miss cycle.
- Address arithmetic: base is line-aligned, so base+i never crosses a line. The top line (0x3FFC..0x3FFF for N=4) is legal.
- MISS while state != IDLE: ignored; no counter increment.
- FLUSH in ISSUE or DRAIN:
  - Next state IDLE. MEM_RDEN1 drops the next cycle.
  - The in-flight read return is discarded: LINE_WE=0 from the cycle after FLUSH is sampled.
  - No TAG_WE, no FILL_DONE. Partially written words are harmless because the valid bit is not set.
- FLUSH in COMMIT: commit still completes; the line is valid.
- FLUSH and MISS together in IDLE: no fill, no count.
- MEM_DOUT1 outside a write cycle is never forwarded as a strobe.

Test Plan:
- Reset, then MISS=1, MISS_ADDR=0x0013 → MEM_ADDR1 = 0x0010, 0x0011, 0x0012, 0x0013 on cycles 1-4. LINE_WE with LINE_IDX 0..3 on cycles 2-5, carrying memory contents. TAG_WE/FILL_DONE on cycle 6 with FILL_TAG=0x0010. MISS_COUNT=1.
- MISS_ADDR=0x3FFE → reads 0x3FFC..0x3FFF, no wrap to 0x0000. FILL_TAG=0x3FFC.
- FLUSH on cycle 3 of a fill → MEM_RDEN1=0 from cycle 4, no LINE_WE from cycle 4, no TAG_WE. Next MISS starts a clean fill from word 0.
- MISS held high through a fill, then a second MISS at 0x0100 → MISS_COUNT=2 (not 7). Second fill starts only after IDLE.
- RST_N low in mid-ISSUE → all outputs 0 immediately, no trailing LINE_WE. First fill after release behaves as in scenario 1.
- MISS_COUNT preloaded near max (CNT_W=4 build, 16 fills) → count saturates at 0xF.

Source files
------------

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache refill sequencer: on a miss, reads one aligned line from
// the memory instruction port word by word, streams each returned word into
// the cache data array, then commits the tag/valid entry and releases fetch.
// Also counts fills started since reset (saturating).
module icache_fill_ctrl #(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 14,
    parameter int CNT_W          = 16,
    localparam int IDX_W         = $clog2(WORDS_PER_LINE)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              MISS,
    input  logic [ADDR_W-1:0] MISS_ADDR,
    input  logic              FLUSH,
    output logic              MEM_RDEN1,
    output logic [ADDR_W-1:0] MEM_ADDR1,
    input  logic [31:0]       MEM_DOUT1,
    output logic              LINE_WE,
    output logic [IDX_W-1:0]  LINE_IDX,
    output logic [31:0]       LINE_DATA,
    output logic              TAG_WE,
    output logic [ADDR_W-1:0] FILL_TAG,
    output logic              STALL,
    output logic              FILL_DONE,
    output logic [CNT_W-1:0]  MISS_COUNT
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        COMMIT
    } state_t;

    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(WORDS_PER_LINE - 1);

    state_t             state;
    logic [IDX_W-1:0]   issue_idx;
    logic [IDX_W-1:0]   next_idx;
    logic [ADDR_W-1:0]  miss_base;

    assign next_idx  = issue_idx + IDX_W'(1);
    assign miss_base = MISS_ADDR & ~LOW_MASK;

    // Fetch holds the PC during the miss cycle itself and for the whole fill
    assign STALL     = (state != IDLE) || (MISS && !FLUSH);
    assign LINE_DATA = MEM_DOUT1;

    // Fill sequencer with registered memory, data-array and tag strobes
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            issue_idx  <= '0;
            MEM_RDEN1  <= 1'b0;
            MEM_ADDR1  <= '0;
            LINE_WE    <= 1'b0;
            LINE_IDX   <= '0;
            TAG_WE     <= 1'b0;
            FILL_TAG   <= '0;
            FILL_DONE  <= 1'b0;
            MISS_COUNT <= '0;
        end else begin
            LINE_WE   <= 1'b0;
            TAG_WE    <= 1'b0;
            FILL_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (MISS && !FLUSH) begin
                        state     <= ISSUE;
                        FILL_TAG  <= miss_base;
                        issue_idx <= '0;
                        MEM_RDEN1 <= 1'b1;
                        MEM_ADDR1 <= miss_base;
                        if (MISS_COUNT != '1) begin
                            MISS_COUNT <= MISS_COUNT + CNT_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (FLUSH) begin
                        // Read issued this cycle returns next cycle and is dropped
                        state     <= IDLE;
                        MEM_RDEN1 <= 1'b0;
                    end else begin
                        LINE_WE  <= MEM_RDEN1;
                        LINE_IDX <= issue_idx;
                        if (issue_idx == '1) begin
                            state     <= DRAIN;
                            MEM_RDEN1 <= 1'b0;
                        end else begin
                            issue_idx <= next_idx;
                            MEM_ADDR1 <= FILL_TAG | ADDR_W'(next_idx);
                        end
                    end
                end
                DRAIN: begin
                    if (FLUSH) begin
                        state <= IDLE;
                    end else begin
                        state     <= COMMIT;
                        TAG_WE    <= 1'b1;
                        FILL_DONE <= 1'b1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: directed scenarios with literal expectations,
// then randomized miss/flush traffic checked every cycle against a model that
// tracks the fill as "cycles since the miss was accepted".
module tb_icache_fill_ctrl;

    localparam int N  = 4;
    localparam int AW = 14;
    localparam int IW = 2;

    logic          CLK   = 1'b0;
    logic          RST_N = 1'b0;
    logic          MISS  = 1'b0;
    logic          FLUSH = 1'b0;
    logic [AW-1:0] MISS_ADDR = '0;
    logic [31:0]   MEM_DOUT1;

    logic          MEM_RDEN1, LINE_WE, TAG_WE, STALL, FILL_DONE;
    logic [AW-1:0] MEM_ADDR1, FILL_TAG;
    logic [IW-1:0] LINE_IDX;
    logic [31:0]   LINE_DATA;
    logic [15:0]   MISS_COUNT;

    logic          rden_4, we_4, tagwe_4, stall_4, done_4;
    logic [AW-1:0] addr_4, tag_4;
    logic [IW-1:0] idx_4;
    logic [31:0]   data_4;
    logic [3:0]    cnt_4;

    icache_fill_ctrl #(.WORDS_PER_LINE(N), .ADDR_W(AW), .CNT_W(16)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .MISS(MISS), .MISS_ADDR(MISS_ADDR), .FLUSH(FLUSH),
        .MEM_RDEN1(MEM_RDEN1), .MEM_ADDR1(MEM_ADDR1), .MEM_DOUT1(MEM_DOUT1),
        .LINE_WE(LINE_WE), .LINE_IDX(LINE_IDX), .LINE_DATA(LINE_DATA),
        .TAG_WE(TAG_WE), .FILL_TAG(FILL_TAG), .STALL(STALL),
        .FILL_DONE(FILL_DONE), .MISS_COUNT(MISS_COUNT)
    );

    icache_fill_ctrl #(.WORDS_PER_LINE(N), .ADDR_W(AW), .CNT_W(4)) u_dut4 (
        .CLK(CLK), .RST_N(RST_N), .MISS(MISS), .MISS_ADDR(MISS_ADDR), .FLUSH(FLUSH),
        .MEM_RDEN1(rden_4), .MEM_ADDR1(addr_4), .MEM_DOUT1(MEM_DOUT1),
        .LINE_WE(we_4), .LINE_IDX(idx_4), .LINE_DATA(data_4),
        .TAG_WE(tagwe_4), .FILL_TAG(tag_4), .STALL(stall_4),
        .FILL_DONE(done_4), .MISS_COUNT(cnt_4)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memf(input logic [AW-1:0] a);
        return {~a[7:0], a, 2'b11, a[7:0]};
    endfunction

    // Memory instruction port: one-cycle read latency, junk when not reading
    always @(posedge CLK) begin
        MEM_DOUT1 <= MEM_RDEN1 ? memf(MEM_ADDR1) : $urandom;
    end

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: m_k counts cycles since acceptance (1..N reads, 2..N+1 writes, N+2 commit)
    bit            m_busy;
    int            m_k;
    int            m_count;
    logic [AW-1:0] m_base;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_busy  <= 1'b0;
            m_k     <= 0;
            m_count <= 0;
        end else if (!m_busy) begin
            if (MISS && !FLUSH) begin
                m_busy  <= 1'b1;
                m_k     <= 1;
                m_base  <= MISS_ADDR - (MISS_ADDR % AW'(N));
                m_count <= m_count + 1;
            end
        end else if ((FLUSH && m_k <= N + 1) || m_k == N + 2) begin
            m_busy <= 1'b0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    bit chk_en = 1'b0;

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge CLK) begin
        if (RST_N && chk_en) begin
            bit e_rd, e_we, e_tag;
            logic [AW-1:0] e_addr;
            e_rd  = m_busy && m_k <= N;
            e_we  = m_busy && m_k >= 2 && m_k <= N + 1;
            e_tag = m_busy && m_k == N + 2;
            chk("stall", STALL, 32'(m_busy || (MISS && !FLUSH)));
            chk("rden", MEM_RDEN1, 32'(e_rd));
            chk("line_we", LINE_WE, 32'(e_we));
            chk("tag_we", TAG_WE, 32'(e_tag));
            chk("fill_done", FILL_DONE, 32'(e_tag));
            chk("count16", MISS_COUNT, (m_count > 65535) ? 32'd65535 : 32'(m_count));
            chk("count4", cnt_4, (m_count > 15) ? 32'd15 : 32'(m_count));
            if (e_rd) begin
                e_addr = m_base + AW'(m_k - 1);
                chk("mem_addr", MEM_ADDR1, 32'(e_addr));
            end
            if (e_we) begin
                e_addr = m_base + AW'(m_k - 2);
                chk("line_idx", LINE_IDX, 32'(m_k - 2));
                chk("line_data", LINE_DATA, memf(e_addr));
            end
            if (e_tag) chk("fill_tag", FILL_TAG, 32'(m_base));
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    // Called in the cycle that becomes cycle 0; leaves MISS high in cycle N+2
    task automatic fill(input logic [AW-1:0] addr, input logic [AW-1:0] base, input int cnt);
        MISS = 1'b1;
        MISS_ADDR = addr;
        #1;
        chk("d_stall_c0", STALL, 1);
        chk("d_rden_c0", MEM_RDEN1, 0);
        for (int c = 1; c <= N + 2; c++) begin
            step();
            #1;
            chk("d_stall", STALL, 1);
            chk("d_rden", MEM_RDEN1, 32'(c <= N));
            chk("d_we", LINE_WE, 32'(c >= 2 && c <= N + 1));
            chk("d_tag_we", TAG_WE, 32'(c == N + 2));
            if (c <= N) chk("d_addr", MEM_ADDR1, 32'(base) + 32'(c - 1));
            if (c >= 2 && c <= N + 1) begin
                chk("d_idx", LINE_IDX, 32'(c - 2));
                chk("d_data", LINE_DATA, memf(base + AW'(c - 2)));
            end
            if (c == N + 2) begin
                chk("d_done", FILL_DONE, 1);
                chk("d_fill_tag", FILL_TAG, 32'(base));
                chk("d_count", MISS_COUNT, 32'(cnt));
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rden"}, MEM_RDEN1, 0);
        chk({tag, "_addr"}, MEM_ADDR1, 0);
        chk({tag, "_we"}, LINE_WE, 0);
        chk({tag, "_idx"}, LINE_IDX, 0);
        chk({tag, "_tag_we"}, TAG_WE, 0);
        chk({tag, "_fill_tag"}, FILL_TAG, 0);
        chk({tag, "_done"}, FILL_DONE, 0);
        chk({tag, "_count"}, MISS_COUNT, 0);
        chk({tag, "_count4"}, cnt_4, 0);
    endtask

    initial begin
        #12;
        chk_all_zero("rst");
        step();
        RST_N = 1'b1;
        chk_en = 1'b1;
        step();

        // Basic fill, then a back-to-back fill with MISS held high throughout
        fill(14'h0013, 14'h0010, 1);
        step();
        fill(14'h0100, 14'h0100, 2);
        MISS = 1'b0;
        step();
        #1;
        chk("idle_stall", STALL, 0);

        // Top line of the address space
        fill(14'h3FFE, 14'h3FFC, 3);
        MISS = 1'b0;
        step();

        // Flush in cycle 3 of a fill, then a clean refill of the same line
        MISS = 1'b1;
        MISS_ADDR = 14'h0205;
        step(); step(); step();
        FLUSH = 1'b1;
        MISS = 1'b0;
        step();
        FLUSH = 1'b0;
        #1;
        chk("fl_rden_c4", MEM_RDEN1, 0);
        chk("fl_we_c4", LINE_WE, 0);
        step();
        #1;
        chk("fl_we_c5", LINE_WE, 0);
        chk("fl_tag_c5", TAG_WE, 0);
        step();
        #1;
        chk("fl_tag_c6", TAG_WE, 0);
        chk("fl_done_c6", FILL_DONE, 0);
        chk("fl_count", MISS_COUNT, 4);
        fill(14'h0205, 14'h0204, 5);
        MISS = 1'b0;
        step();

        // Asynchronous reset in the middle of ISSUE
        MISS = 1'b1;
        MISS_ADDR = 14'h0042;
        step(); step();
        RST_N = 1'b0;
        MISS = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        step();
        #1;
        chk("mid_rst_trail_we", LINE_WE, 0);
        step();
        RST_N = 1'b1;
        step();
        fill(14'h0013, 14'h0010, 1);
        MISS = 1'b0;
        step();

        // Randomized miss / flush traffic
        for (int i = 0; i < 700; i++) begin
            step();
            if (FILL_DONE) MISS = 1'b0;
            FLUSH = ($urandom_range(0, 9) == 0);
            if (FLUSH && $urandom_range(0, 1) == 1) MISS = 1'b0;
            if (!MISS && $urandom_range(0, 2) == 0) begin
                MISS = 1'b1;
                MISS_ADDR = AW'($urandom);
            end
        end
        MISS = 1'b0;
        FLUSH = 1'b0;
        for (int i = 0; i < N + 4; i++) step();
        #1;
        chk("enough_fills", 32'(m_count >= 16), 1);
        chk("sat4_final", cnt_4, 32'hF);
        chk("final_idle_stall", STALL, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
